// File: rtl/rgb444_grey_scanner_pkg.sv
// Shared constants and types for the RGB444 greyscale scanner and its
// conversion stage.
package sift_pkg;

  localparam int unsigned IMG_W_DEF = 128;
  localparam int unsigned IMG_H_DEF = 128;

  localparam int unsigned PIXEL_W = 12;
  localparam int unsigned GREY_W  = 8;

  // Luma weights; they sum to 256 so the scaled result always fits GREY_W bits.
  localparam int unsigned W_R = 77;
  localparam int unsigned W_G = 150;
  localparam int unsigned W_B = 29;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } scanner_state_t;

endpackage

// File: rtl/rgb444_grey_scanner_if.sv
// Memory-side bus of the scanner: image read port and greyscale write port.
interface rgb444_grey_scanner_if
  import sift_pkg::*;
#(
  parameter int unsigned ADDR_W = $clog2(IMG_W_DEF * IMG_H_DEF)
);

  logic [ADDR_W-1:0]  rd_addr_out;
  logic [PIXEL_W-1:0] rd_data_in;
  logic [ADDR_W-1:0]  wr_addr_out;
  logic [GREY_W-1:0]  wr_data_out;
  logic               wr_en_out;

  modport master (
    output rd_addr_out,
    input  rd_data_in,
    output wr_addr_out,
    output wr_data_out,
    output wr_en_out
  );

  modport slave (
    input  rd_addr_out,
    output rd_data_in,
    input  wr_addr_out,
    input  wr_data_out,
    input  wr_en_out
  );

endinterface

// File: rtl/rgb444_to_grey.sv
// Single registered stage converting an RGB444 pixel to 8-bit greyscale.
// grey_out holds its last value while valid_in is low.
module rgb444_to_grey
  import sift_pkg::*;
(
  input  logic               clk_100mhz,
  input  logic               sys_rst_n,
  input  logic               valid_in,
  input  logic [PIXEL_W-1:0] pixel_in,
  output logic               valid_out,
  output logic [GREY_W-1:0]  grey_out
);

  logic [7:0]        r8;
  logic [7:0]        g8;
  logic [7:0]        b8;
  logic [15:0]       acc;
  logic [GREY_W-1:0] grey_next;

  // Expand each nibble to 8 bits by replication, then weight and scale by 1/256.
  always_comb begin
    r8        = {pixel_in[11:8], pixel_in[11:8]};
    g8        = {pixel_in[7:4],  pixel_in[7:4]};
    b8        = {pixel_in[3:0],  pixel_in[3:0]};
    acc       = 16'(W_R) * {8'h00, r8}
              + 16'(W_G) * {8'h00, g8}
              + 16'(W_B) * {8'h00, b8};
    grey_next = GREY_W'(acc >> 8);
  end

  // Register the result; data only moves when a valid pixel arrives.
  always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      valid_out <= 1'b0;
      grey_out  <= '0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        grey_out <= grey_next;
      end
    end
  end

endmodule

// File: rtl/rgb444_grey_scanner.sv
// Scans one frame of the image BRAM on request, converts every pixel to
// greyscale and writes it to the output BRAM at the same address.
module rgb444_grey_scanner
  import sift_pkg::*;
#(
  parameter int unsigned IMG_W        = IMG_W_DEF,
  parameter int unsigned IMG_H        = IMG_H_DEF,
  parameter int unsigned READ_LATENCY = 2
)
(
  input  logic                  clk_100mhz,
  input  logic                  sys_rst_n,
  input  logic                  start_in,
  output logic                  busy_out,
  output logic                  done_out,
  rgb444_grey_scanner_if.master mem_if
);

  localparam int unsigned N      = IMG_W * IMG_H;
  localparam int unsigned ADDR_W = $clog2(N);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

  scanner_state_t            state;
  logic [ADDR_W-1:0]         rd_addr;
  logic                      issue;
  logic [READ_LATENCY-1:0]   vld_pipe;
  logic [ADDR_W-1:0]         addr_pipe [READ_LATENCY];
  logic [ADDR_W-1:0]         wr_addr_q;
  logic                      wr_en;
  logic [GREY_W-1:0]         wr_data;

  assign issue = (state == SCAN);

  // Scan controller: address generation plus registered busy/done.
  // DRAIN exits once the read delay line is empty; at that moment the final
  // pixel sits in the conversion register, so done lands one cycle after
  // the last write.
  always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      rd_addr  <= '0;
      busy_out <= 1'b0;
      done_out <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            state    <= SCAN;
            rd_addr  <= '0;
            busy_out <= 1'b1;
          end
        end
        SCAN: begin
          if (rd_addr == LAST_ADDR) begin
            state <= DRAIN;
          end else begin
            rd_addr <= rd_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (vld_pipe == '0) begin
            state    <= DONE;
            rd_addr  <= '0;
            busy_out <= 1'b0;
            done_out <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          rd_addr  <= '0;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

  // Valid/address delay line matching the BRAM read latency.
  always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vld_pipe <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        addr_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0]  <= issue;
      addr_pipe[0] <= rd_addr;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
    end
  end

  // Write address follows its pixel through the conversion stage; holds otherwise.
  always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_addr_q <= '0;
    end else if (vld_pipe[READ_LATENCY-1]) begin
      wr_addr_q <= addr_pipe[READ_LATENCY-1];
    end
  end

  rgb444_to_grey u_conv (
    .clk_100mhz (clk_100mhz),
    .sys_rst_n  (sys_rst_n),
    .valid_in   (vld_pipe[READ_LATENCY-1]),
    .pixel_in   (mem_if.rd_data_in),
    .valid_out  (wr_en),
    .grey_out   (wr_data)
  );

  assign mem_if.rd_addr_out = rd_addr;
  assign mem_if.wr_addr_out = wr_addr_q;
  assign mem_if.wr_data_out = wr_data;
  assign mem_if.wr_en_out   = wr_en;

endmodule

// File: tb/tb_rgb444_grey_scanner.sv
// Bench for rgb444_grey_scanner: four instances (128x128/RL2, 2x2/RL2,
// 4x4/RL1, 4x4/RL4), each with a behavioural latency-modelled BRAM.
module tb_rgb444_grey_scanner;

  logic       clk_100mhz = 1'b0;
  logic       sys_rst_n  = 1'b0;
  logic [3:0] start_v    = '0;
  logic       busy0, busy1, busy2, busy3;
  logic       done0, done1, done2, done3;
  int         cyc = 0;

  always #5 clk_100mhz = ~clk_100mhz;
  always @(posedge clk_100mhz) cyc <= cyc + 1;

  rgb444_grey_scanner_if #(.ADDR_W(14)) if0 ();
  rgb444_grey_scanner_if #(.ADDR_W(2))  if1 ();
  rgb444_grey_scanner_if #(.ADDR_W(4))  if2 ();
  rgb444_grey_scanner_if #(.ADDR_W(4))  if3 ();

  rgb444_grey_scanner #(.IMG_W(128), .IMG_H(128), .READ_LATENCY(2)) dut0 (
    .clk_100mhz(clk_100mhz), .sys_rst_n(sys_rst_n), .start_in(start_v[0]),
    .busy_out(busy0), .done_out(done0), .mem_if(if0));
  rgb444_grey_scanner #(.IMG_W(2), .IMG_H(2), .READ_LATENCY(2)) dut1 (
    .clk_100mhz(clk_100mhz), .sys_rst_n(sys_rst_n), .start_in(start_v[1]),
    .busy_out(busy1), .done_out(done1), .mem_if(if1));
  rgb444_grey_scanner #(.IMG_W(4), .IMG_H(4), .READ_LATENCY(1)) dut2 (
    .clk_100mhz(clk_100mhz), .sys_rst_n(sys_rst_n), .start_in(start_v[2]),
    .busy_out(busy2), .done_out(done2), .mem_if(if2));
  rgb444_grey_scanner #(.IMG_W(4), .IMG_H(4), .READ_LATENCY(4)) dut3 (
    .clk_100mhz(clk_100mhz), .sys_rst_n(sys_rst_n), .start_in(start_v[3]),
    .busy_out(busy3), .done_out(done3), .mem_if(if3));

  // Image memories with read latency modelled as an address history.
  logic [11:0] mem0 [16384];
  logic [11:0] mem1 [4];
  logic [11:0] mem2 [16];
  logic [11:0] mem3 [16];
  logic [13:0] h0 [2] = '{default: '0};
  logic [1:0]  h1 [2] = '{default: '0};
  logic [3:0]  h2 [1] = '{default: '0};
  logic [3:0]  h3 [4] = '{default: '0};

  always @(posedge clk_100mhz) begin
    h0[1] <= h0[0]; h0[0] <= if0.rd_addr_out;
    h1[1] <= h1[0]; h1[0] <= if1.rd_addr_out;
    h2[0] <= if2.rd_addr_out;
    h3[0] <= if3.rd_addr_out;
    for (int i = 1; i < 4; i++) h3[i] <= h3[i-1];
  end

  assign if0.rd_data_in = mem0[h0[1]];
  assign if1.rd_data_in = mem1[h1[1]];
  assign if2.rd_data_in = mem2[h2[0]];
  assign if3.rd_data_in = mem3[h3[3]];

  // Monitor of the selected instance: logs writes, done pulses, busy cycles.
  int   sel = 0;
  int   log_cyc[$], log_addr[$], log_data[$], done_log[$];
  int   busy_cnt = 0;
  logic cur_we, cur_busy, cur_done;
  int   cur_ra, cur_wa, cur_wd;

  always @(negedge clk_100mhz) begin
    case (sel)
      0: begin
        cur_we = if0.wr_en_out; cur_ra = int'(if0.rd_addr_out); cur_wa = int'(if0.wr_addr_out);
        cur_wd = int'(if0.wr_data_out); cur_busy = busy0; cur_done = done0;
      end
      1: begin
        cur_we = if1.wr_en_out; cur_ra = int'(if1.rd_addr_out); cur_wa = int'(if1.wr_addr_out);
        cur_wd = int'(if1.wr_data_out); cur_busy = busy1; cur_done = done1;
      end
      2: begin
        cur_we = if2.wr_en_out; cur_ra = int'(if2.rd_addr_out); cur_wa = int'(if2.wr_addr_out);
        cur_wd = int'(if2.wr_data_out); cur_busy = busy2; cur_done = done2;
      end
      default: begin
        cur_we = if3.wr_en_out; cur_ra = int'(if3.rd_addr_out); cur_wa = int'(if3.wr_addr_out);
        cur_wd = int'(if3.wr_data_out); cur_busy = busy3; cur_done = done3;
      end
    endcase
    if (cur_we) begin
      log_cyc.push_back(cyc);
      log_addr.push_back(cur_wa);
      log_data.push_back(cur_wd);
    end
    if (cur_done) done_log.push_back(cyc);
    if (cur_busy) busy_cnt++;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int base_w, base_d, base_b;
  int exp_grey [16384];

  typedef struct {
    logic [11:0] px;
    int          grey;
  } vec_t;
  vec_t vecs [8];

  // Reference luma: nibble n scales to 8 bits as n*17, weights 77/150/29, floor /256.
  function automatic int grey_ref(input int px);
    int r8, g8, b8;
    r8 = ((px >> 8) & 15) * 17;
    g8 = ((px >> 4) & 15) * 17;
    b8 = (px & 15) * 17;
    return (77 * r8 + 150 * g8 + 29 * b8) / 256;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_100mhz);
    #1;
  endtask

  task automatic mark();
    base_w = log_cyc.size();
    base_d = done_log.size();
    base_b = busy_cnt;
  endtask

  task automatic do_start(output int t0);
    start_v[sel] = 1'b1;
    t0 = cyc;
    tick();
    start_v = '0;
  endtask

  // Waits for done (bounded); optionally pulses start at cycles p1/p2 after t0.
  task automatic wait_done(input int t0, input int budget, input int p1, input int p2);
    int i;
    i = 0;
    while (done_log.size() == base_d && i < budget) begin
      tick();
      i++;
      start_v = '0;
      if (cyc - t0 == p1 || cyc - t0 == p2) start_v[sel] = 1'b1;
    end
    start_v = '0;
    check("done_out seen within budget", done_log.size() - base_d, 1);
  endtask

  task automatic verify(input string nm, input int n, input int rl, input int t0);
    int nw, bad_t, bad_a, bad_d;
    nw = log_cyc.size() - base_w;
    bad_t = 0; bad_a = 0; bad_d = 0;
    check({nm, " write count"}, nw, n);
    for (int i = 0; i < nw && i < n; i++) begin
      if (log_cyc[base_w+i] != t0 + i + rl + 2) bad_t++;
      if (log_addr[base_w+i] != i) bad_a++;
      if (log_data[base_w+i] != exp_grey[i]) bad_d++;
    end
    check({nm, " writes at wrong cycle"}, bad_t, 0);
    check({nm, " writes at wrong address"}, bad_a, 0);
    check({nm, " writes with wrong grey"}, bad_d, 0);
    check({nm, " done pulses"}, done_log.size() - base_d, 1);
    check({nm, " done cycle after start"},
          (done_log.size() > base_d) ? done_log[base_d] - t0 : -1, n + rl + 2);
    check({nm, " busy cycles"}, busy_cnt - base_b, n + rl + 1);
  endtask

  initial begin
    int t0, bad, i;
    vecs[0] = '{12'hFFF, 255}; vecs[1] = '{12'h000, 0};
    vecs[2] = '{12'hF00, 76};  vecs[3] = '{12'h0F0, 149};
    vecs[4] = '{12'h00F, 28};  vecs[5] = '{12'h888, 136};
    vecs[6] = '{12'h5A3, 130}; vecs[7] = '{12'h7C1, 157};
    for (int k = 0; k < 16384; k++) mem0[k] = '0;
    for (int k = 0; k < 16; k++) begin mem2[k] = '0; mem3[k] = '0; end
    for (int k = 0; k < 4; k++) mem1[k] = '0;

    // Reset and idle
    repeat (2) tick();
    check("reset rd_addr", cur_ra, 0);
    check("reset wr_en", int'(cur_we), 0);
    check("reset busy", int'(cur_busy), 0);
    check("reset done", int'(cur_done), 0);
    repeat (3) tick();
    sys_rst_n = 1'b1;
    mark();
    bad = 0;
    repeat (100) begin
      tick();
      if (cur_we || cur_busy || cur_done || cur_ra != 0 || cur_wa != 0 || cur_wd != 0) bad++;
    end
    check("idle cycles with nonzero outputs", bad, 0);
    check("idle writes", log_cyc.size() - base_w, 0);

    // Frame A: image[k]=k, extra start pulses at +10 and +500 ignored
    sel = 0;
    for (int k = 0; k < 16384; k++) begin
      mem0[k] = 12'(k);
      exp_grey[k] = grey_ref(k & 12'hFFF);
    end
    mark();
    do_start(t0);
    wait_done(t0, 16384 + 30, 10, 500);
    verify("frameA", 16384, 2, t0);

    // Frame B: random image after done, then hold behaviour
    for (int k = 0; k < 16384; k++) begin
      mem0[k] = 12'($urandom);
      exp_grey[k] = grey_ref(int'(mem0[k]));
    end
    tick();
    mark();
    do_start(t0);
    wait_done(t0, 16384 + 30, -1, -1);
    verify("frameB", 16384, 2, t0);
    repeat (3) tick();
    check("hold wr_en low", int'(cur_we), 0);
    check("hold wr_addr", cur_wa, 16383);
    check("hold wr_data", cur_wd, exp_grey[16383]);
    check("post-done rd_addr", cur_ra, 0);
    check("post-done busy", int'(cur_busy), 0);

    // Reset mid-scan at rd_addr=1000
    do_start(t0);
    i = 0;
    while (cur_ra != 1000 && i < 2000) begin tick(); i++; end
    check("reached rd_addr 1000", cur_ra, 1000);
    sys_rst_n = 1'b0;
    #1;
    check("async reset rd_addr", int'(if0.rd_addr_out), 0);
    check("async reset wr_en", int'(if0.wr_en_out), 0);
    check("async reset wr_addr", int'(if0.wr_addr_out), 0);
    check("async reset wr_data", int'(if0.wr_data_out), 0);
    check("async reset busy", int'(busy0), 0);
    check("async reset done", int'(done0), 0);
    mark();
    repeat (5) tick();
    sys_rst_n = 1'b1;
    repeat (30) tick();
    check("writes after reset", log_cyc.size() - base_w, 0);
    check("done after reset", done_log.size() - base_d, 0);
    check("busy after reset", busy_cnt - base_b, 0);
    mark();
    do_start(t0);
    wait_done(t0, 16384 + 30, -1, -1);
    verify("frame after reset", 16384, 2, t0);

    // Arithmetic table, two 2x2 frames back to back; start in DONE is ignored
    sel = 1;
    tick();
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 4; k++) begin
        mem1[k] = vecs[f*4+k].px;
        exp_grey[k] = vecs[f*4+k].grey;
      end
      mark();
      if (f == 1) begin
        start_v[1] = 1'b1;
        tick();
      end
      do_start(t0);
      wait_done(t0, 40, -1, -1);
      verify((f == 0) ? "arith frame0" : "arith frame1", 4, 2, t0);
    end

    // Latency sweep with random images
    for (int s = 2; s < 4; s++) begin
      sel = s;
      tick();
      for (int f = 0; f < 2; f++) begin
        for (int k = 0; k < 16; k++) begin
          if (s == 2) begin mem2[k] = 12'($urandom); exp_grey[k] = grey_ref(int'(mem2[k])); end
          else        begin mem3[k] = 12'($urandom); exp_grey[k] = grey_ref(int'(mem3[k])); end
        end
        tick();
        mark();
        do_start(t0);
        wait_done(t0, 60, -1, -1);
        verify((s == 2) ? "sweep RL1" : "sweep RL4", 16, (s == 2) ? 1 : 4, t0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
